// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble display path: slot geometry, the blank
// code and the loader FSM state encoding.
package nibble_pkg;

    localparam int NIBBLE_W  = 4;
    localparam int NUM_SLOTS = 6;
    localparam int SEL_W     = 3;

    localparam logic [NIBBLE_W-1:0] BLANK_NIBBLE = 4'b1111;
    localparam logic [SEL_W-1:0]    LAST_SLOT    = SEL_W'(NUM_SLOTS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

endpackage

// File: rtl/nibble_frame_loader.sv
// nibble_frame_loader: write side of the six-slot display bank.
// Nibbles arrive over valid/ready into a shadow bank; the sixth nibble commits
// the whole frame to o_slot0..5 on one edge so the mux never sees a torn frame.
// Optional abort flag o_frame_err is built when NIBBLE_FRAME_LOADER_ERR_EN is defined.
module nibble_frame_loader
    import nibble_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [NIBBLE_W-1:0] i_data,
    input  logic                i_valid,
    output logic                o_ready,
    output logic [SEL_W-1:0]    o_ptr,
    output logic [NIBBLE_W-1:0] o_slot0,
    output logic [NIBBLE_W-1:0] o_slot1,
    output logic [NIBBLE_W-1:0] o_slot2,
    output logic [NIBBLE_W-1:0] o_slot3,
    output logic [NIBBLE_W-1:0] o_slot4,
    output logic [NIBBLE_W-1:0] o_slot5,
`ifdef NIBBLE_FRAME_LOADER_ERR_EN
    output logic                o_frame_err,
`endif
    output logic                o_frame_done
);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic                done_q;
    logic [NIBBLE_W-1:0] shadow_q [NUM_SLOTS-1];
    logic [NIBBLE_W-1:0] slot_q   [NUM_SLOTS];

    // A start pulse always wins over a coincident nibble.
    logic xfer;
    logic commit;
    assign xfer   = i_valid && (state_q == ST_LOAD) && !i_start;
    assign commit = xfer && (ptr_q == LAST_SLOT);

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: start (re)enters LOAD, the final nibble returns to IDLE
    always_comb begin
        state_d = state_q;
        if (i_start)     state_d = ST_LOAD;
        else if (commit) state_d = ST_IDLE;
    end

    // FSM outputs and committed slot fan-out
    always_comb begin
        o_ready      = (state_q == ST_LOAD);
        o_ptr        = ptr_q;
        o_frame_done = done_q;
        o_slot0      = slot_q[0];
        o_slot1      = slot_q[1];
        o_slot2      = slot_q[2];
        o_slot3      = slot_q[3];
        o_slot4      = slot_q[4];
        o_slot5      = slot_q[5];
    end

    // Pointer next value: cleared by start or commit, advanced per transfer
    always_comb begin
        ptr_d = ptr_q;
        if (i_start || commit) ptr_d = '0;
        else if (xfer)         ptr_d = ptr_q + SEL_W'(1);
    end

    // Pointer and frame-done pulse registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q  <= '0;
            done_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            done_q <= commit;
        end
    end

    // Shadow bank: holds slots 0..4 of the frame being assembled; slot 5
    // comes straight from i_data at commit, so it needs no shadow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_SLOTS - 1; i++) shadow_q[i] <= BLANK_NIBBLE;
        end else if (xfer && !commit) begin
            for (int i = 0; i < NUM_SLOTS - 1; i++) begin
                if (ptr_q == SEL_W'(i)) shadow_q[i] <= i_data;
            end
        end
    end

    // Committed bank: updated atomically on the final transfer, else held
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= BLANK_NIBBLE;
        end else if (commit) begin
            for (int i = 0; i < NUM_SLOTS - 1; i++) slot_q[i] <= shadow_q[i];
            slot_q[NUM_SLOTS-1] <= i_data;
        end
    end

`ifdef NIBBLE_FRAME_LOADER_ERR_EN
    logic err_q;

    // Abort flag: set when a frame in progress is restarted, cleared on commit
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                                                 err_q <= 1'b0;
        else if (i_start && (state_q == ST_LOAD) && (ptr_q != '0)) err_q <= 1'b1;
        else if (commit)                                           err_q <= 1'b0;
    end

    assign o_frame_err = err_q;
`endif

endmodule

// File: doc/nibble_frame_loader.md
Name: nibble_frame_loader

Overview:
- Fills the six 4-bit display slots that the 6:1 nibble mux selects from. It is the write side of that slot bank.
- Accepts a sequential stream of nibbles over a valid/ready handshake and places each nibble in the slot given by an internal pointer.
- Uses double buffering: a complete frame of six nibbles is committed to the outputs atomically, so the mux never sees a partial frame.

Parameters:
- NIBBLE_W, 4, width of each slot (fixed at 4 for this block; exposed for package consistency).
- NUM_SLOTS, 6, slots per frame; pointer width is 3 bits.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  one-cycle pulse; begins or restarts a frame at slot 0.
- i_data  input  4  nibble for the current slot.
- i_valid  input  1  i_data valid.
- o_ready  output  1  loader accepts a nibble this cycle.
- o_ptr  output  3  slot index the next accepted nibble goes to (0..5).
- o_slot0 .. o_slot5  output  4 each  committed frame contents; feed the mux inputs 0..5.
- o_frame_done  output  1  one-cycle pulse the cycle after a frame commits.

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE, o_ptr=0, o_ready=0, o_frame_done=0.
  - All shadow registers and o_slot0..5 = 4'b1111 (blank code, same as the mux default).
- FSM states: IDLE, LOAD.
- IDLE:
  - o_ready=0; i_valid is ignored.
  - i_start=1 -> LOAD, o_ptr=0.
- LOAD:
  - o_ready=1. Transfer occurs when i_valid and o_ready are both high at a rising edge.
  - Transfer with o_ptr<5: shadow[o_ptr]<=i_data, o_ptr<=o_ptr+1.
  - Transfer with o_ptr==5: all six o_slotN are updated on the same edge (slots 0..4 from shadow, slot 5 from i_data). o_ptr<=0, state->IDLE, o_frame_done=1 on the following cycle only.
- Latency: last nibble accepted at edge N -> new frame visible on o_slot* after edge N, o_frame_done high during cycle N..N+1.
- Simultaneous i_start and i_valid (either state): i_start wins and i_data is discarded. o_ptr=0, state=LOAD, shadow contents are not cleared but will be overwritten.
- i_start mid-frame (LOAD, o_ptr 1..5): the frame is abandoned, o_slot* are unchanged, o_ptr=0, and loading restarts.
- Pointer never exceeds 5; values 6 and 7 are unreachable.
- o_slot* hold their values indefinitely between commits.
- Reset mid-frame returns all outputs to 4'b1111 immediately, independent of the clock.

Optional Feature:
- Macro: NIBBLE_FRAME_LOADER_ERR_EN.
- Defined:
  - Adds output o_frame_err (1 bit), which is reset to 0.
  - Set to 1 when i_start arrives in LOAD with o_ptr!=0 (aborted frame).
  - Cleared to 0 on the next successful commit.
- Undefined: the port is absent and aborts are silent; all other behaviour is identical.

Decomposition:
- Shared package (nibble_pkg):
  - NIBBLE_W=4, NUM_SLOTS=6, SEL_W=3.
  - BLANK_NIBBLE=4'b1111.
  - FSM state enum {ST_IDLE, ST_LOAD}.
- No sub-module is needed. The shadow bank plus commit logic stays inline; the pointer/FSM is small enough to share one always block per register group.

Test Plan:
- Reset: assert i_rst mid-clock -> all o_slot*=4'hF, o_ptr=0, o_ready=0 before the next edge.
- Full frame: i_start, then 6 back-to-back transfers of 1,2,3,4,5,6 -> o_slot0..5 = 1..6 after the 6th edge, o_frame_done high exactly 1 cycle, o_ptr=0, o_ready=0.
- Gapped valid: same frame with i_valid low on alternate cycles -> identical result. o_slot* stay at their previous frame values until the commit edge.
- Abort: load A,B,C, pulse i_start, then load 9,8,7,6,5,4 -> o_slot0..5 = 9,8,7,6,5,4. With ERR_EN, o_frame_err=1 after the abort and 0 after the commit.
- Start+valid collision: i_start and i_valid with data=7 in the same cycle -> 7 discarded, o_ptr=0; the next six transfers define the frame.
- Idle valid: i_valid=1, data=3 with no i_start -> no change to o_ptr or o_slot*, o_frame_done stays 0.
